// File: rtl/bus_timer_slave.sv
// Memory-mapped one-shot/periodic timer behind a strobe/ready slave bus.
// Each access completes WAIT_CYCLES wait states after being sampled, with a one-cycle bus_rdy_o pulse.
module bus_timer_slave #(
    parameter int BUS_ADD_WIDTH = 30,
    parameter int BUS_DAT_WIDTH = 32,
    parameter int WAIT_CYCLES   = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     bus_cs_i,
    input  logic                     bus_as_i,
    input  logic                     bus_rw_i,
    input  logic [BUS_ADD_WIDTH-1:0] bus_addr_i,
    input  logic [BUS_DAT_WIDTH-1:0] bus_wr_data_i,
    output logic [BUS_DAT_WIDTH-1:0] bus_rd_data_o,
    output logic                     bus_rdy_o,
    output logic                     irq_o
);
    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_STAT   = 2'd1;
    localparam logic [1:0] ADDR_EXPIRE = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RDY  = 2'd2
    } state_t;

    state_t                   state_reg;
    logic [3:0]               wait_cnt_reg;
    logic [1:0]               addr_reg;
    logic                     rw_reg;
    logic [BUS_DAT_WIDTH-1:0] wr_data_reg;
    logic                     rdy_reg;
    logic [BUS_DAT_WIDTH-1:0] rd_buf_reg;

    logic                     start_reg;
    logic                     periodic_reg;
    logic                     expired_reg;
    logic [BUS_DAT_WIDTH-1:0] expire_reg;
    logic [BUS_DAT_WIDTH-1:0] count_reg;

    logic                     access;
    logic                     commit;
    logic                     commit_rw;
    logic [1:0]               commit_addr;
    logic [BUS_DAT_WIDTH-1:0] commit_data;
    logic [BUS_DAT_WIDTH-1:0] rd_value;
    logic                     wr_en;
    logic                     hit;
    logic                     addr_unused;

    assign addr_unused = ^bus_addr_i[BUS_ADD_WIDTH-1:2];
    assign access      = bus_cs_i & bus_as_i;
    assign hit         = start_reg && (count_reg == expire_reg);

    // With no wait states the commit happens on the sampling edge itself,
    // so the live bus inputs are used instead of the latched copies.
    always_comb begin
        commit      = 1'b0;
        commit_rw   = rw_reg;
        commit_addr = addr_reg;
        commit_data = wr_data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (access && (WAIT_CYCLES == 0)) begin
                    commit      = 1'b1;
                    commit_rw   = bus_rw_i;
                    commit_addr = bus_addr_i[1:0];
                    commit_data = bus_wr_data_i;
                end
            end
            ST_WAIT: commit = access && (wait_cnt_reg == 4'd1);
            default: commit = 1'b0;
        endcase
    end

    assign wr_en = commit & ~commit_rw;

    always_comb begin
        rd_value = '0;
        case (commit_addr)
            ADDR_CTRL:   rd_value[1:0] = {periodic_reg, start_reg};
            ADDR_STAT:   rd_value[0]   = expired_reg;
            ADDR_EXPIRE: rd_value      = expire_reg;
            default:     rd_value      = count_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            rw_reg       <= 1'b0;
            wr_data_reg  <= '0;
            rdy_reg      <= 1'b0;
            rd_buf_reg   <= '0;
        end else begin
            rdy_reg    <= commit;
            rd_buf_reg <= (commit && commit_rw) ? rd_value : '0;
            case (state_reg)
                ST_IDLE: begin
                    if (access) begin
                        addr_reg    <= bus_addr_i[1:0];
                        rw_reg      <= bus_rw_i;
                        wr_data_reg <= bus_wr_data_i;
                        if (WAIT_CYCLES == 0) begin
                            state_reg <= ST_RDY;
                        end else begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= 4'(WAIT_CYCLES);
                        end
                    end
                end
                ST_WAIT: begin
                    if (!access) begin
                        state_reg    <= ST_IDLE;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 4'd1;
                        if (wait_cnt_reg == 4'd1) begin
                            state_reg <= ST_RDY;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // Bus writes are applied after the timer update so they win for CTRL/COUNT,
    // while an expiry is applied last so it wins over a STAT clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            start_reg    <= 1'b0;
            periodic_reg <= 1'b0;
            expired_reg  <= 1'b0;
            expire_reg   <= '0;
            count_reg    <= '0;
        end else begin
            if (start_reg) begin
                count_reg <= hit ? '0 : count_reg + BUS_DAT_WIDTH'(1);
            end
            if (hit && !periodic_reg) begin
                start_reg <= 1'b0;
            end
            if (wr_en) begin
                case (commit_addr)
                    ADDR_CTRL: begin
                        start_reg    <= commit_data[0];
                        periodic_reg <= commit_data[1];
                    end
                    ADDR_STAT: begin
                        if (commit_data[0]) expired_reg <= 1'b0;
                    end
                    ADDR_EXPIRE: expire_reg <= commit_data;
                    default:     count_reg  <= commit_data;
                endcase
            end
            if (hit) begin
                expired_reg <= 1'b1;
            end
        end
    end

    assign bus_rdy_o     = rdy_reg;
    assign bus_rd_data_o = rd_buf_reg;
    assign irq_o         = expired_reg;

endmodule

// File: tb/tb_bus_timer_slave.sv
// Scoreboard bench for bus_timer_slave: three instances with 1, 3 and 0 wait states.
module tb_bus_timer_slave;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n   [N];
    logic        cs      [N];
    logic        as_s    [N];
    logic        rw      [N];
    logic [29:0] addr_s  [N];
    logic [31:0] wdata   [N];
    logic [31:0] rd_data [N];
    logic        rdy     [N];
    logic        irq     [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        bus_timer_slave #(
            .BUS_ADD_WIDTH(30),
            .BUS_DAT_WIDTH(32),
            .WAIT_CYCLES  ((gi == 0) ? 1 : ((gi == 1) ? 3 : 0))
        ) u_dut (
            .clk_i        (clk),
            .rst_n_i      (rst_n[gi]),
            .bus_cs_i     (cs[gi]),
            .bus_as_i     (as_s[gi]),
            .bus_rw_i     (rw[gi]),
            .bus_addr_i   (addr_s[gi]),
            .bus_wr_data_i(wdata[gi]),
            .bus_rd_data_o(rd_data[gi]),
            .bus_rdy_o    (rdy[gi]),
            .irq_o        (irq[gi])
        );
    end

    typedef struct {
        int          dut;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    function automatic int wc_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 3 : 0);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every ready pulse pops one expected response; idle data must be zero.
    always @(negedge clk) begin
        for (int d = 0; d < N; d++) begin
            if (rdy[d] === 1'b1) begin
                tests++;
                if (sb_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_rdy dut%0d: got rd_data=%h, required no response", d, rd_data[d]);
                end else begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.dut != d || rd_data[d] !== mon_e.data) begin
                        fails++;
                        $display("[TB] FAIL %s: got dut%0d rd_data=%h, required dut%0d rd_data=%h",
                                 mon_e.name, d, rd_data[d], mon_e.dut, mon_e.data);
                    end else begin
                        $display("[TB] dut%0d %s rd_data=%h", d, mon_e.name, rd_data[d]);
                    end
                end
            end else begin
                tests++;
                if (rd_data[d] !== 32'h0) begin
                    fails++;
                    $display("[TB] FAIL idle_rd_data dut%0d: got %h, required 00000000", d, rd_data[d]);
                end
            end
        end
    end

    task automatic bus_access(input int d, input logic rd, input logic [1:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_rd, input string name);
        int   n;
        logic got;
        @(negedge clk);
        cs[d]     = 1'b1;
        as_s[d]   = 1'b1;
        rw[d]     = rd;
        addr_s[d] = {28'h0, a};
        wdata[d]  = wd;
        sb_q.push_back('{dut: d, data: (rd ? exp_rd : 32'h0), name: name});
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (rdy[d] === 1'b1) got = 1'b1;
        end
        cs[d]   = 1'b0;
        as_s[d] = 1'b0;
        tests++;
        if (!got || n != wc_of(d) + 1) begin
            fails++;
            $display("[TB] FAIL %s_latency: got %0d cycles (seen=%0d), required %0d", name, n, got, wc_of(d) + 1);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic seen;

    initial begin
        for (int d = 0; d < N; d++) begin
            rst_n[d] = 1'b0; cs[d] = 1'b0; as_s[d] = 1'b0; rw[d] = 1'b0;
            addr_s[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < N; d++) rst_n[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < N; d++) begin
            check($sformatf("reset_irq_dut%0d", d), {31'b0, irq[d]}, 32'h0);
            check($sformatf("reset_rdy_dut%0d", d), {31'b0, rdy[d]}, 32'h0);
            check($sformatf("reset_rd_data_dut%0d", d), rd_data[d], 32'h0);
        end
        bus_access(1, 1'b1, 2'd0, 32'h0, 32'h0, "reset_ctrl_read");

        // Basic write/readback with one wait state.
        bus_access(0, 1'b0, 2'd2, 32'h5, 32'h0, "wr_expire_5");
        bus_access(0, 1'b1, 2'd2, 32'h0, 32'h5, "rd_expire_5");

        // One-shot: expires on the fourth edge after START, then stops.
        bus_access(0, 1'b0, 2'd2, 32'h3, 32'h0, "wr_expire_3");
        bus_access(0, 1'b0, 2'd0, 32'h1, 32'h0, "wr_ctrl_start");
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check($sformatf("oneshot_irq_k%0d", k), {31'b0, irq[0]}, (k == 4) ? 32'h1 : 32'h0);
        end
        bus_access(0, 1'b1, 2'd0, 32'h0, 32'h0, "oneshot_ctrl_cleared");
        bus_access(0, 1'b1, 2'd3, 32'h0, 32'h0, "oneshot_count_held");
        bus_access(0, 1'b1, 2'd1, 32'h0, 32'h1, "oneshot_stat_set");
        bus_access(0, 1'b0, 2'd1, 32'h1, 32'h0, "oneshot_stat_clear");
        check("oneshot_irq_cleared", {31'b0, irq[0]}, 32'h0);

        // Periodic, EXPIRE=2: expiry every third edge.
        bus_access(0, 1'b0, 2'd2, 32'h2, 32'h0, "wr_expire_2");
        bus_access(0, 1'b0, 2'd0, 32'h3, 32'h0, "wr_ctrl_periodic");
        check("periodic_irq_start", {31'b0, irq[0]}, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            check($sformatf("periodic_irq_k%0d", k), {31'b0, irq[0]}, (k == 3) ? 32'h1 : 32'h0);
        end
        bus_access(0, 1'b0, 2'd1, 32'h1, 32'h0, "stat_clear_on_expiry");
        check("set_wins_over_clear", {31'b0, irq[0]}, 32'h1);
        @(negedge clk);
        bus_access(0, 1'b0, 2'd1, 32'h1, 32'h0, "stat_clear_between");
        check("periodic_irq_cleared", {31'b0, irq[0]}, 32'h0);
        @(negedge clk);
        check("periodic_irq_still_clear", {31'b0, irq[0]}, 32'h0);
        @(negedge clk);
        check("periodic_irq_reasserted", {31'b0, irq[0]}, 32'h1);
        bus_access(0, 1'b1, 2'd3, 32'h0, 32'h2, "count_pre_edge_value");
        bus_access(0, 1'b0, 2'd0, 32'h0, 32'h0, "ctrl_stop_on_expiry");
        bus_access(0, 1'b1, 2'd0, 32'h0, 32'h0, "ctrl_write_wins");
        bus_access(0, 1'b1, 2'd3, 32'h0, 32'h0, "count_after_stop");
        bus_access(0, 1'b0, 2'd1, 32'h1, 32'h0, "stat_clear_final");

        // EXPIRE=0 periodic: expired every cycle, COUNT pinned at 0.
        bus_access(0, 1'b0, 2'd2, 32'h0, 32'h0, "wr_expire_0");
        bus_access(0, 1'b0, 2'd0, 32'h3, 32'h0, "wr_ctrl_periodic0");
        bus_access(0, 1'b1, 2'd3, 32'h0, 32'h0, "expire0_count_zero");
        bus_access(0, 1'b1, 2'd1, 32'h0, 32'h1, "expire0_stat_set");

        // Asynchronous reset in the middle of a write while the timer runs.
        @(negedge clk);
        cs[0] = 1'b1; as_s[0] = 1'b1; rw[0] = 1'b0; addr_s[0] = 30'd2; wdata[0] = 32'h77;
        @(posedge clk);
        @(negedge clk);
        #1 rst_n[0] = 1'b0;
        #1;
        check("async_reset_irq", {31'b0, irq[0]}, 32'h0);
        check("async_reset_rdy", {31'b0, rdy[0]}, 32'h0);
        check("async_reset_rd_data", rd_data[0], 32'h0);
        cs[0] = 1'b0; as_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n[0] = 1'b1;
        bus_access(0, 1'b1, 2'd0, 32'h0, 32'h0, "post_reset_ctrl");
        bus_access(0, 1'b1, 2'd2, 32'h0, 32'h0, "post_reset_expire");
        check("post_reset_irq", {31'b0, irq[0]}, 32'h0);

        // Aborted COUNT write with three wait states.
        @(negedge clk);
        cs[1] = 1'b1; as_s[1] = 1'b1; rw[1] = 1'b0; addr_s[1] = 30'd3; wdata[1] = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        cs[1] = 1'b0; as_s[1] = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[1] === 1'b1) seen = 1'b1;
        end
        check("abort_no_rdy", {31'b0, seen}, 32'h0);
        bus_access(1, 1'b1, 2'd3, 32'h0, 32'h0, "abort_count_unchanged");
        bus_access(1, 1'b0, 2'd3, 32'hA5, 32'h0, "wr_count_a5");
        bus_access(1, 1'b1, 2'd3, 32'h0, 32'hA5, "rd_count_a5");

        // Zero wait states: held strobe gives back-to-back accesses.
        bus_access(2, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0, "wr_ctrl_all_ones");
        @(negedge clk);
        cs[2] = 1'b1; as_s[2] = 1'b1; rw[2] = 1'b1; addr_s[2] = 30'd0;
        sb_q.push_back('{dut: 2, data: 32'h2, name: "b2b_ctrl_rd_a"});
        sb_q.push_back('{dut: 2, data: 32'h2, name: "b2b_ctrl_rd_b"});
        @(posedge clk);
        @(negedge clk);
        check("b2b_rdy_0", {31'b0, rdy[2]}, 32'h1);
        @(negedge clk);
        check("b2b_rdy_1", {31'b0, rdy[2]}, 32'h0);
        @(negedge clk);
        check("b2b_rdy_2", {31'b0, rdy[2]}, 32'h1);
        cs[2] = 1'b0; as_s[2] = 1'b0;
        @(negedge clk);
        check("b2b_rdy_3", {31'b0, rdy[2]}, 32'h0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
